main_mem_responder: RTL and testbench
=====================================

MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

Interface
REQ-001 SHALL have parameter MEM_BLOCKS, default 1024, number of 128-bit lines stored.
REQ-002 SHALL have parameter LATENCY, default 4, cycles from request acceptance to ready pulse; legal range 1..15.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port mem_req  input  mem_req_t  request from the cache controller; fields addr[31:0] byte address, data[127:0] write line, rw (1 = write), valid.
REQ-006 SHALL have port mem_rsp  output  mem_data_t  response; fields data[127:0] read line, ready (one-cycle completion pulse).

Function
REQ-007 SHALL implement FSM states IDLE, WAIT, RESP, GAP.
REQ-008 IDLE: on mem_req.valid=1, latch addr, data and rw, load the latency counter with LATENCY-1, go to WAIT, or go directly to RESP if LATENCY=1.
REQ-009 WAIT: decrement the counter each cycle; at 0, go to RESP; mem_req changes during WAIT SHALL be ignored.
REQ-010 Line index SHALL be latched addr[4+log2(MEM_BLOCKS)-1:4]; addr[3:0] and upper bits ignored, so out-of-range addresses wrap modulo MEM_BLOCKS.
REQ-011 RESP, read (rw=0): mem_rsp.ready=1 and mem_rsp.data = stored line at latched index, both for exactly one cycle.
REQ-012 RESP, write (rw=1): store the latched data at the latched index on the RESP clock edge; mem_rsp.ready=1 for one cycle; mem_rsp.data = latched write data.
REQ-013 Acceptance-to-ready latency SHALL be exactly LATENCY cycles: valid sampled at edge N, ready high in the cycle following edge N+LATENCY-1.
REQ-014 GAP: one cycle with ready=0 and valid ignored, so the requester can drop valid; then return to IDLE.
REQ-015 Valid still high in IDLE after GAP SHALL be accepted as a new request (back-to-back throughput: one request per LATENCY+2 cycles).
REQ-016 Outside RESP, mem_rsp.ready SHALL be 0 and mem_rsp.data SHALL hold its last value.
REQ-017 A read of a line written by the immediately preceding request SHALL return the new data.

Reset
REQ-018 While reset=1, the FSM SHALL go to IDLE, the counter and latched request fields SHALL clear, and mem_rsp SHALL be all zero.
REQ-019 Reset during WAIT or RESP SHALL abort the transaction: no ready pulse, no storage write on that edge.
REQ-020 Storage contents SHALL NOT be cleared by reset.
REQ-021 A request with valid=1 in the first cycle after reset deassertion SHALL be accepted.

Structure
REQ-022 mem_req_t, mem_data_t and the LATENCY default SHALL live in cache_definitions_pkg alongside cache_req_t and cache_data_t.
REQ-023 Storage SHALL be a sub-module main_mem_array: single-port, MEM_BLOCKS x 128, asynchronous read, synchronous write on we, no reset.
REQ-024 FSM, counter and request latch SHALL be in main_mem_responder; no other sub-modules.

Verification
REQ-025 Write then read: write addr 0x0000_0010, data 0xDEADBEEF_0000_0001_CAFEF00D_12345678, then read addr 0x0000_0010 -> ready 4 cycles after each acceptance; read data equals the written line.
REQ-026 Latency sweep: LATENCY=1 and LATENCY=15, read addr 0 -> ready exactly 1 and 15 cycles after acceptance, one-cycle pulse each.
REQ-027 Back-to-back: valid held high across 3 reads -> acceptances spaced LATENCY+2 cycles apart, no missed or duplicated ready.
REQ-028 Wrap: write 0xA5 repeated at addr 0x0000_4000 (MEM_BLOCKS=1024), read addr 0x0 -> returns the 0xA5 line; addr[3:0]=0xF reads the same line.
REQ-029 Reset mid-op: assert reset in WAIT of a write to addr 0x20 -> no ready, mem_rsp=0, later read of 0x20 returns the prior content.
REQ-030 Stability: change mem_req.addr during WAIT -> response uses the address latched at acceptance.

Source files
------------

// File: rtl/cache_definitions_pkg.sv
// Shared cache/memory bus payloads and main-memory responder defaults.
package cache_definitions_pkg;

  localparam int unsigned ADDR_W              = 32;
  localparam int unsigned LINE_W              = 128;
  localparam int unsigned WORD_W              = 32;
  localparam int unsigned CNT_W               = 4;
  localparam int unsigned MEM_LATENCY_DEFAULT = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
    logic              rw;
    logic              valid;
  } mem_req_t;

  typedef struct packed {
    logic [LINE_W-1:0] data;
    logic              ready;
  } mem_data_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
    logic              rw;
    logic              valid;
  } cache_req_t;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              ready;
  } cache_data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } mem_state_e;

endpackage

// File: rtl/main_mem_array.sv
// Single-port line storage: asynchronous read, synchronous write, contents survive reset.
module main_mem_array #(
  parameter int unsigned MEM_BLOCKS = 1024,
  parameter int unsigned IDX_W      = 10,
  parameter int unsigned LINE_W     = 128
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  addr,
  input  logic              we,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata_c
);

  logic [LINE_W-1:0] mem [MEM_BLOCKS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata_c = mem[addr];

endmodule

// File: rtl/main_mem_responder.sv
// Fixed-latency main-memory model answering one cache-line request at a time.
module main_mem_responder
  import cache_definitions_pkg::*;
#(
  parameter int unsigned MEM_BLOCKS = 1024,
  parameter int unsigned LATENCY    = MEM_LATENCY_DEFAULT
) (
  input  logic      clk,
  input  logic      reset,
  input  mem_req_t  mem_req,
  output mem_data_t mem_rsp
);

  localparam int unsigned IDX_W = (MEM_BLOCKS > 1) ? $clog2(MEM_BLOCKS) : 1;

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              rw_q, rw_d;
  mem_data_t         rsp_d;
  logic              mem_we;
  logic [LINE_W-1:0] mem_rdata_c;

  // Byte offset and bits above the line index do not select storage.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_req.addr[ADDR_W-1:4+IDX_W], mem_req.addr[3:0]};

  main_mem_array #(
    .MEM_BLOCKS (MEM_BLOCKS),
    .IDX_W      (IDX_W),
    .LINE_W     (LINE_W)
  ) u_array (
    .clk     (clk),
    .addr    (idx_d),
    .we      (mem_we),
    .wdata   (wdata_q),
    .rdata_c (mem_rdata_c)
  );

  // Next state, request latch, counter and the response loaded on entry to RESP.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    rw_d       = rw_q;
    mem_we     = 1'b0;
    rsp_d.data  = mem_rsp.data;
    rsp_d.ready = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_req.valid) begin
          idx_d   = mem_req.addr[4 +: IDX_W];
          wdata_d = mem_req.data;
          rw_d    = mem_req.rw;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) begin
          state_d = RESP;
        end
      end
      RESP: begin
        mem_we  = rw_q & ~reset;
        state_d = GAP;
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Index is stable through RESP, so the single port serves both read and write.
    if (state_d == RESP) begin
      rsp_d.ready = 1'b1;
      rsp_d.data  = rw_d ? wdata_d : mem_rdata_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      mem_rsp <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      mem_rsp <= rsp_d;
    end
  end

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed checks of main_mem_responder at LATENCY 4, 1 and 15.
module tb_main_mem_responder;
  import cache_definitions_pkg::*;

  logic      clk;
  logic      reset;
  mem_req_t  req [3];
  mem_data_t rsp [3];

  int tests;
  int fails;

  localparam logic [127:0] DB  = 128'hDEADBEEF_0000_0001_CAFEF00D_12345678;
  localparam logic [127:0] A5  = {16{8'hA5}};
  localparam logic [127:0] P20 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] P30 = 128'h3030_3030_0000_FFFF_1234_5678_9ABC_DEF0;
  localparam logic [127:0] BAD = {4{32'h0BAD_0BAD}};
  localparam logic [127:0] L1P = 128'h0101_0202_0303_0404_0505_0606_0707_0808;
  localparam logic [127:0] LFP = 128'hF0F0_0F0F_AAAA_5555_C3C3_3C3C_9999_6666;

  main_mem_responder #(.MEM_BLOCKS(1024), .LATENCY(4)) dut (
    .clk(clk), .reset(reset), .mem_req(req[0]), .mem_rsp(rsp[0]));
  main_mem_responder #(.MEM_BLOCKS(1024), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset), .mem_req(req[1]), .mem_rsp(rsp[1]));
  main_mem_responder #(.MEM_BLOCKS(1024), .LATENCY(15)) dut_l15 (
    .clk(clk), .reset(reset), .mem_req(req[2]), .mem_rsp(rsp[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         rw;
    logic [31:0]  addr;
    logic [127:0] data;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic launch(input int d, input logic [31:0] addr, input logic [127:0] data,
                        input logic rw);
    req[d].addr  = addr;
    req[d].data  = data;
    req[d].rw    = rw;
    req[d].valid = 1'b1;
  endtask

  // Acceptance edge is the next posedge; request fields are scrambled right after it.
  task automatic await_rsp(input int d, input int lat, input logic [127:0] exp,
                           input string name);
    int k;
    @(posedge clk);
    @(negedge clk);
    req[d].valid = 1'b0;
    req[d].addr  = req[d].addr + 32'h0000_0100;
    req[d].data  = ~req[d].data;
    k = 1;
    while (!rsp[d].ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_latency"}, 129'(k), 129'(lat));
    chk({name, "_data"}, 129'(rsp[d].data), 129'(exp));
    @(negedge clk);
    chk({name, "_pulse"}, 129'(rsp[d].ready), 129'(0));
  endtask

  task automatic txn(input int d, input logic [31:0] addr, input logic [127:0] data,
                     input logic rw, input int lat, input logic [127:0] exp,
                     input string name);
    @(negedge clk);
    launch(d, addr, data, rw);
    await_rsp(d, lat, exp, name);
  endtask

  int           n;
  int           seen;
  int           at  [3];
  logic [127:0] dat [3];
  logic [127:0] bexp [3];

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) req[i] = '0;

    vecs[0] = '{1'b1, 32'h0000_0010, DB,     DB};
    vecs[1] = '{1'b0, 32'h0000_0010, '0,     DB};
    vecs[2] = '{1'b1, 32'h0000_4000, A5,     A5};
    vecs[3] = '{1'b0, 32'h0000_0000, '0,     A5};
    vecs[4] = '{1'b0, 32'h0000_000F, '0,     A5};
    vecs[5] = '{1'b1, 32'h0000_0020, P20,    P20};
    vecs[6] = '{1'b0, 32'h0000_0020, '0,     P20};
    vecs[7] = '{1'b1, 32'h0000_0030, P30,    P30};

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("reset_rsp%0d", i), 129'(rsp[i]), 129'(0));
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      txn(0, vecs[i].addr, vecs[i].data, vecs[i].rw, 4, vecs[i].exp, $sformatf("vec%0d", i));
    txn(0, 32'h0000_4038, '0, 1'b0, 4, P30, "wrap_idx3");

    // Latency extremes
    txn(1, 32'h0, L1P, 1'b1, 1, L1P, "l1_write");
    txn(1, 32'h0, '0, 1'b0, 1, L1P, "l1_read");
    txn(2, 32'h0, LFP, 1'b1, 15, LFP, "l15_write");
    txn(2, 32'h0, '0, 1'b0, 15, LFP, "l15_read");

    // Reset while a write to 0x20 is waiting
    @(negedge clk);
    launch(0, 32'h0000_0020, BAD, 1'b1);
    @(posedge clk);
    @(negedge clk);
    req[0].valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_rsp_zero", 129'(rsp[0]), 129'(0));
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp[0].ready) seen++;
    end
    chk("abort_no_ready", 129'(seen), 129'(0));
    chk("abort_rsp_still_zero", 129'(rsp[0]), 129'(0));

    // Request presented during reset is taken on the first cycle after release
    @(negedge clk);
    reset = 1'b1;
    launch(0, 32'h0000_0020, '0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    await_rsp(0, 4, P20, "post_reset_read");

    // Back-to-back reads with valid held high
    bexp[0] = DB;
    bexp[1] = P20;
    bexp[2] = A5;
    for (int i = 0; i < 3; i++) begin
      at[i]  = 0;
      dat[i] = '0;
    end
    n = 0;
    @(negedge clk);
    launch(0, 32'h0000_0010, '0, 1'b0);
    @(posedge clk);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 1)  req[0].addr = 32'h0000_0020;
      if (k == 7)  req[0].addr = 32'h0000_0000;
      if (k == 13) req[0].valid = 1'b0;
      if (rsp[0].ready) begin
        if (n < 3) begin
          at[n]  = k;
          dat[n] = rsp[0].data;
        end
        n++;
      end
    end
    chk("b2b_count", 129'(n), 129'(3));
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b_cycle%0d", i), 129'(at[i]), 129'(4 + 6 * i));
      chk($sformatf("b2b_data%0d", i), 129'(dat[i]), 129'(bexp[i]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
